// File: rtl/ttt_ps2_keys_if.sv
// PS/2 line and key-level bundle for ttt_ps2_keys.
// The slave modport is the receiver side. It takes the raw PS/2 lines and drives
// the key levels and byte status. The master modport is the keyboard/consumer side.
interface ttt_ps2_keys_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       enter;
  logic       space;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  up, down, left, right, enter, space, code, code_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output up, down, left, right, enter, space, code, code_valid, frame_err
  );
endinterface

// File: rtl/ttt_ps2_keys.sv
// PS/2 keyboard receiver and set-2 scan-code decoder for the tic-tac-toe keys.
// It synchronizes and filters ps2_clk, assembles 11-bit frames, and tracks the
// E0/F0 prefixes. It drives one held level per key.
// Optional build macro TTT_WASD_EN adds W/A/S/D (1D/1C/1B/23) as extra
// up/left/down/right sources. Each of these is tracked separately from the
// arrow keys.
module ttt_ps2_keys #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 50000
) (
  input logic           clk,
  input logic           reset_n,
  ttt_ps2_keys_if.slave bus
);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_meta_reg, clk_sync_reg, data_meta_reg, data_sync_reg;
  logic          clk_filt_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          sample_pt;

  state_t        state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_reg, parity_next;
  logic [TW-1:0] to_cnt_reg;
  logic          byte_done, byte_good, timeout_hit;

  logic          ext_reg, ext_next, brk_reg, brk_next;
  logic          up_reg, up_next, down_reg, down_next;
  logic          left_reg, left_next, right_reg, right_next;
  logic          enter_reg, enter_next, space_reg, space_next;
  logic [7:0]    code_reg;
  logic          code_valid_reg, frame_err_reg;
`ifdef TTT_WASD_EN
  logic          w_up_reg, w_up_next, w_down_reg, w_down_next;
  logic          w_left_reg, w_left_next, w_right_reg, w_right_next;
`endif

  // Two-flop synchronizers, plus a glitch filter on the PS/2 clock level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_meta_reg  <= 1'b0;
      clk_sync_reg  <= 1'b0;
      data_meta_reg <= 1'b0;
      data_sync_reg <= 1'b0;
      clk_filt_reg  <= 1'b0;
      filt_cnt_reg  <= '0;
    end else begin
      clk_meta_reg  <= bus.ps2_clk;
      clk_sync_reg  <= clk_meta_reg;
      data_meta_reg <= bus.ps2_data;
      data_sync_reg <= data_meta_reg;
      if (clk_sync_reg == clk_filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
        clk_filt_reg <= clk_sync_reg;
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + FW'(1);
      end
    end
  end

  // A sample point is the cycle the filtered clock falls. Data is taken on that cycle.
  assign sample_pt = clk_filt_reg && !clk_sync_reg && (filt_cnt_reg == FW'(FILTER_LEN - 1));

  // Frame FSM state, shift register and inactivity counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      to_cnt_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      if (sample_pt || timeout_hit || state_reg == IDLE)
        to_cnt_reg <= '0;
      else
        to_cnt_reg <= to_cnt_reg + TW'(1);
    end
  end

  // Frame FSM next state: start, 8 data bits LSB first, odd parity, stop.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    byte_done    = 1'b0;
    byte_good    = 1'b0;
    timeout_hit  = 1'b0;
    if (sample_pt) begin
      case (state_reg)
        IDLE: begin
          if (!data_sync_reg) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          shift_next   = {data_sync_reg, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          parity_next = data_sync_reg;
          state_next  = STOP;
        end
        STOP: begin
          byte_done  = 1'b1;
          byte_good  = data_sync_reg && (^{shift_reg, parity_reg});
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (state_reg != IDLE && to_cnt_reg == TW'(TIMEOUT - 1)) begin
      timeout_hit = 1'b1;
      state_next  = IDLE;
    end
  end

  // Scan-code decoder. It handles the prefix flags and the per-key held levels.
  always_comb begin
    ext_next   = ext_reg;
    brk_next   = brk_reg;
    up_next    = up_reg;
    down_next  = down_reg;
    left_next  = left_reg;
    right_next = right_reg;
    enter_next = enter_reg;
    space_next = space_reg;
`ifdef TTT_WASD_EN
    w_up_next    = w_up_reg;
    w_down_next  = w_down_reg;
    w_left_next  = w_left_reg;
    w_right_next = w_right_reg;
`endif
    if (timeout_hit || (byte_done && !byte_good)) begin
      ext_next = 1'b0;
      brk_next = 1'b0;
    end else if (byte_done && byte_good) begin
      if (shift_reg == 8'hE0) begin
        ext_next = 1'b1;
      end else if (shift_reg == 8'hF0) begin
        brk_next = 1'b1;
      end else begin
        ext_next = 1'b0;
        brk_next = 1'b0;
        if (ext_reg) begin
          case (shift_reg)
            8'h75:   up_next    = ~brk_reg;
            8'h72:   down_next  = ~brk_reg;
            8'h6B:   left_next  = ~brk_reg;
            8'h74:   right_next = ~brk_reg;
            8'h5A:   enter_next = ~brk_reg;
            default: ;
          endcase
        end else begin
          case (shift_reg)
            8'h5A:   enter_next   = ~brk_reg;
            8'h29:   space_next   = ~brk_reg;
`ifdef TTT_WASD_EN
            8'h1D:   w_up_next    = ~brk_reg;
            8'h1B:   w_down_next  = ~brk_reg;
            8'h1C:   w_left_next  = ~brk_reg;
            8'h23:   w_right_next = ~brk_reg;
`endif
            default: ;
          endcase
        end
      end
    end
  end

  // Decoder state and byte-status outputs. All of them change on the cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ext_reg        <= 1'b0;
      brk_reg        <= 1'b0;
      up_reg         <= 1'b0;
      down_reg       <= 1'b0;
      left_reg       <= 1'b0;
      right_reg      <= 1'b0;
      enter_reg      <= 1'b0;
      space_reg      <= 1'b0;
      code_reg       <= 8'h00;
      code_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
`ifdef TTT_WASD_EN
      w_up_reg       <= 1'b0;
      w_down_reg     <= 1'b0;
      w_left_reg     <= 1'b0;
      w_right_reg    <= 1'b0;
`endif
    end else begin
      ext_reg        <= ext_next;
      brk_reg        <= brk_next;
      up_reg         <= up_next;
      down_reg       <= down_next;
      left_reg       <= left_next;
      right_reg      <= right_next;
      enter_reg      <= enter_next;
      space_reg      <= space_next;
      if (byte_done && byte_good) code_reg <= shift_reg;
      code_valid_reg <= byte_done && byte_good;
      frame_err_reg  <= (byte_done && !byte_good) || timeout_hit;
`ifdef TTT_WASD_EN
      w_up_reg       <= w_up_next;
      w_down_reg     <= w_down_next;
      w_left_reg     <= w_left_next;
      w_right_reg    <= w_right_next;
`endif
    end
  end

`ifdef TTT_WASD_EN
  assign bus.up    = up_reg    | w_up_reg;
  assign bus.down  = down_reg  | w_down_reg;
  assign bus.left  = left_reg  | w_left_reg;
  assign bus.right = right_reg | w_right_reg;
`else
  assign bus.up    = up_reg;
  assign bus.down  = down_reg;
  assign bus.left  = left_reg;
  assign bus.right = right_reg;
`endif
  assign bus.enter      = enter_reg;
  assign bus.space      = space_reg;
  assign bus.code       = code_reg;
  assign bus.code_valid = code_valid_reg;
  assign bus.frame_err  = frame_err_reg;
endmodule

// File: tb/tb_ttt_ps2_keys.sv
// Self-checking bench for ttt_ps2_keys. It uses a table of PS/2 frames with
// hand-computed key levels, plus sequences for latency, glitches, timeout,
// reset and the WASD keys.
// Key vectors are ordered {up, down, left, right, enter, space}.
module tb_ttt_ps2_keys;
  localparam int TO = 50000;
`ifdef TTT_WASD_EN
  localparam bit WASD = 1'b1;
`else
  localparam bit WASD = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    bit         bad;
    logic [5:0] exp_keys;
    logic [7:0] exp_code;
    int         exp_valid;
    int         exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  ttt_ps2_keys_if bus ();

  ttt_ps2_keys #(.FILTER_LEN(4), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #20 clk = ~clk;

  int compared = 0;
  int failed   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  logic [5:0] keys_prev = '0;
  logic [5:0] keys_at_valid = '0;
  logic [5:0] keys_before_valid = '0;
  vec_t vecs[$];

  function automatic logic [5:0] keys();
    return {bus.up, bus.down, bus.left, bus.right, bus.enter, bus.space};
  endfunction

  // Count output pulses, and snapshot the key levels around each code_valid.
  always @(negedge clk) begin
    if (bus.code_valid === 1'b1) begin
      valid_cnt         <= valid_cnt + 1;
      keys_at_valid     <= keys();
      keys_before_valid <= keys_prev;
    end
    if (bus.frame_err === 1'b1) err_cnt <= err_cnt + 1;
    keys_prev <= keys();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    wait_cyc(6);
    bus.ps2_clk = 1'b0;
    wait_cyc(12);
    bus.ps2_clk = 1'b1;
    wait_cyc(6);
  endtask

  task automatic glitch();
    bus.ps2_clk = 1'b0;
    wait_cyc(2);
    bus.ps2_clk = 1'b1;
    wait_cyc(8);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(bad ? ^d : ~^d);
    ps2_bit(1'b1);
    wait_cyc(10);
  endtask

  task automatic add(input logic [7:0] d, input bit bad, input logic [5:0] k,
                     input logic [7:0] c, input int v, input int e);
    vec_t x;
    x.data = d; x.bad = bad; x.exp_keys = k; x.exp_code = c; x.exp_valid = v; x.exp_err = e;
    vecs.push_back(x);
  endtask

  initial begin
    int v0, e0;
    logic [10:0] fr;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset_n = 1'b0;
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(20);
    check("reset_keys", 32'(keys()), 32'h0);
    check("reset_code", 32'(bus.code), 32'h00);
    check("reset_valid", 32'(valid_cnt), 32'd0);
    check("reset_err", 32'(err_cnt), 32'd0);

    add(8'h5A, 0, 6'b000010, 8'h5A, 1, 0);
    add(8'hF0, 0, 6'b000010, 8'hF0, 1, 0);
    add(8'h5A, 0, 6'b000000, 8'h5A, 1, 0);
    add(8'hE0, 0, 6'b000000, 8'hE0, 1, 0);
    add(8'h75, 0, 6'b100000, 8'h75, 1, 0);
    add(8'hE0, 0, 6'b100000, 8'hE0, 1, 0);
    add(8'h75, 0, 6'b100000, 8'h75, 1, 0);
    add(8'hE0, 0, 6'b100000, 8'hE0, 1, 0);
    add(8'h74, 0, 6'b100100, 8'h74, 1, 0);
    add(8'h75, 0, 6'b100100, 8'h75, 1, 0);
    add(8'hE0, 0, 6'b100100, 8'hE0, 1, 0);
    add(8'hF0, 0, 6'b100100, 8'hF0, 1, 0);
    add(8'h75, 0, 6'b000100, 8'h75, 1, 0);
    add(8'hE0, 0, 6'b000100, 8'hE0, 1, 0);
    add(8'hF0, 0, 6'b000100, 8'hF0, 1, 0);
    add(8'h74, 0, 6'b000000, 8'h74, 1, 0);
    add(8'h29, 1, 6'b000000, 8'h74, 0, 1);
    add(8'h29, 0, 6'b000001, 8'h29, 1, 0);
    add(8'hF0, 0, 6'b000001, 8'hF0, 1, 0);
    add(8'h29, 1, 6'b000001, 8'hF0, 0, 1);
    add(8'h29, 0, 6'b000001, 8'h29, 1, 0);
    add(8'h72, 0, 6'b000001, 8'h72, 1, 0);
    add(8'hE0, 0, 6'b000001, 8'hE0, 1, 0);
    add(8'h5A, 0, 6'b000011, 8'h5A, 1, 0);
    add(8'hE0, 0, 6'b000011, 8'hE0, 1, 0);
    add(8'h6B, 0, 6'b001011, 8'h6B, 1, 0);
    add(8'hE0, 0, 6'b001011, 8'hE0, 1, 0);
    add(8'h72, 0, 6'b011011, 8'h72, 1, 0);
    add(8'h1D, 0, WASD ? 6'b111011 : 6'b011011, 8'h1D, 1, 0);
    add(8'hF0, 0, WASD ? 6'b111011 : 6'b011011, 8'hF0, 1, 0);
    add(8'h1D, 0, 6'b011011, 8'h1D, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].data, vecs[i].bad);
      check($sformatf("vec%0d_keys", i), 32'(keys()), 32'(vecs[i].exp_keys));
      check($sformatf("vec%0d_code", i), 32'(bus.code), 32'(vecs[i].exp_code));
      check($sformatf("vec%0d_valid", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
    end

    // The WASD up key and the arrow up key are held independently.
    send_frame(8'h1D, 0);
    check("wasd_press_w", 32'(bus.up), 32'(WASD));
    send_frame(8'hE0, 0); send_frame(8'h75, 0);
    check("wasd_press_arrow", 32'(bus.up), 32'd1);
    send_frame(8'hF0, 0); send_frame(8'h1D, 0);
    check("wasd_release_w", 32'(bus.up), 32'd1);
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
    check("wasd_release_arrow", 32'(bus.up), 32'd0);

    // The key level changes on the same cycle as the code_valid pulse.
    send_frame(8'hF0, 0); send_frame(8'h29, 0);
    check("lat_release", 32'(keys()), 32'(6'b011010));
    send_frame(8'h29, 0);
    check("lat_at_valid", 32'(keys_at_valid), 32'(6'b011011));
    check("lat_before_valid", 32'(keys_before_valid), 32'(6'b011010));

    // Short clock glitches in mid-frame must not take samples.
    send_frame(8'hF0, 0);
    v0 = valid_cnt;
    e0 = err_cnt;
    fr = {1'b1, ~^8'h29, 8'h29, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_bit(fr[i]);
      if (i == 2 || i == 6) begin glitch(); glitch(); end
    end
    wait_cyc(10);
    check("glitch_keys", 32'(keys()), 32'(6'b011010));
    check("glitch_code", 32'(bus.code), 32'h29);
    check("glitch_valid", 32'(valid_cnt - v0), 32'd1);
    check("glitch_err", 32'(err_cnt - e0), 32'd0);

    // A partial frame is abandoned after TIMEOUT idle cycles.
    e0 = err_cnt;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    wait_cyc(TO - 50);
    check("to_early", 32'(err_cnt - e0), 32'd0);
    wait_cyc(100);
    check("to_err", 32'(err_cnt - e0), 32'd1);
    check("to_keys", 32'(keys()), 32'(6'b011010));
    send_frame(8'h29, 0);
    check("to_then_space", 32'(keys()), 32'(6'b011011));

    // A reset in mid-frame clears everything, including the pending E0.
    send_frame(8'hE0, 0);
    ps2_bit(1'b0); ps2_bit(1'b1);
    reset_n = 1'b0;
    wait_cyc(2);
    check("rst_keys", 32'(keys()), 32'h0);
    check("rst_code", 32'(bus.code), 32'h00);
    check("rst_code_valid", 32'(bus.code_valid), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    reset_n = 1'b1;
    bus.ps2_data = 1'b1;
    wait_cyc(20);
    send_frame(8'h75, 0);
    check("rst_75_up", 32'(bus.up), 32'd0);
    check("rst_75_code", 32'(bus.code), 32'h75);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
